// File: rtl/cmplx_combine.sv
// -----------------------------------------------------------------------------
// cmplx_combine
// Final stage of the complex-multiply path. It takes the four real partial
// products of (a+jb)*(c+jd) in the order ac, bd, ad, bc. It forms
// re = ac - bd and im = ad + bc, and presents the pair over a valid/ready
// handshake. A framing violation raises a one-cycle frame_err pulse.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   prod        signed partial product (W bits)
//   prod_valid  prod is valid this cycle
//   prod_first  prod is the ac term, i.e. the start of a frame
//   prod_ready  block accepts prod this cycle (combinational)
//   re          signed real part, ac - bd (OW bits, registered)
//   im          signed imaginary part, ad + bc (OW bits, registered)
//   out_valid   re/im hold a result that has not been consumed yet
//   out_ready   consumer takes re/im when out_valid & out_ready
//   frame_err   one-cycle pulse on a framing violation (registered)
// -----------------------------------------------------------------------------
module cmplx_combine #(
    parameter int unsigned W  = 8,
    parameter int unsigned OW = W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  prod,
    input  logic                 prod_valid,
    input  logic                 prod_first,
    output logic                 prod_ready,
    output logic signed [OW-1:0] re,
    output logic signed [OW-1:0] im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err
);

    // Position of the next expected term within a frame.
    typedef enum logic [1:0] {
        EXP_AC = 2'd0,
        EXP_BD = 2'd1,
        EXP_AD = 2'd2,
        EXP_BC = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [W-1:0]  ac_q, ac_d;
    logic signed [W-1:0]  bd_q, bd_d;
    logic signed [W-1:0]  ad_q, ad_d;
    logic signed [OW-1:0] re_q, re_d;
    logic signed [OW-1:0] im_q, im_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 accept;

    // Only the bc term can stall. It waits while an unconsumed result
    // occupies the output register.
    assign prod_ready = !((state_q == EXP_BC) && out_valid_q && !out_ready);
    assign accept     = prod_valid && prod_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EXP_AC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. prod_first always restarts a frame, from any state.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (prod_first) begin
                state_d = EXP_BD;
            end else begin
                unique case (state_q)
                    EXP_AC:  state_d = EXP_AC;  // orphan word is dropped
                    EXP_BD:  state_d = EXP_AD;
                    EXP_AD:  state_d = EXP_BC;
                    EXP_BC:  state_d = EXP_AC;
                    default: state_d = EXP_AC;
                endcase
            end
        end
    end

    // Datapath and output next-values.
    always_comb begin
        ac_d        = ac_q;
        bd_d        = bd_q;
        ad_d        = ad_q;
        re_d        = re_q;
        im_d        = im_q;
        frame_err_d = 1'b0;
        // A transfer empties the output register unless a new bc reloads it below.
        out_valid_d = out_valid_q && !out_ready;

        if (accept) begin
            if (prod_first) begin
                // A restart mid-frame discards the partials collected so far.
                frame_err_d = (state_q != EXP_AC);
                ac_d        = prod;
                bd_d        = '0;
                ad_d        = '0;
            end else begin
                unique case (state_q)
                    EXP_AC: frame_err_d = 1'b1;
                    EXP_BD: bd_d = prod;
                    EXP_AD: ad_d = prod;
                    EXP_BC: begin
                        // Sign-extend before the add/sub. OW = W+1 cannot overflow.
                        re_d        = OW'(ac_q) - OW'(bd_q);
                        im_d        = OW'(ad_q) + OW'(prod);
                        out_valid_d = 1'b1;
                    end
                    default: frame_err_d = 1'b0;
                endcase
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q        <= '0;
            bd_q        <= '0;
            ad_q        <= '0;
            re_q        <= '0;
            im_q        <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ac_q        <= ac_d;
            bd_q        <= bd_d;
            ad_q        <= ad_d;
            re_q        <= re_d;
            im_q        <= im_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign re        = re_q;
    assign im        = im_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cmplx_combine.sv
// -----------------------------------------------------------------------------
// tb_cmplx_combine
// Self-checking bench for cmplx_combine. It runs directed scenarios first,
// then randomized traffic. Both are compared against a frame-level reference
// model: a position counter, a term array and a single output slot.
// -----------------------------------------------------------------------------
module tb_cmplx_combine;

    logic              clk;
    logic              rst;
    logic signed [7:0] prod;
    logic              prod_valid;
    logic              prod_first;
    logic              prod_ready;
    logic signed [8:0] re;
    logic signed [8:0] im;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;

    cmplx_combine #(.W(8), .OW(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_ready (prod_ready),
        .re         (re),
        .im         (im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int pos;          // index of the next expected term: 0=ac 1=bd 2=ad 3=bc
    int terms [4];
    bit m_valid;
    bit m_err;
    int m_re;
    int m_im;
    bit last_acc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos     = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_re    = 0;
        m_im    = 0;
        for (int i = 0; i < 4; i++) terms[i] = 0;
    endtask

    // Runs one clock cycle with the given inputs and checks the DUT against the model.
    task automatic step(input bit v, input bit f, input int p, input bit ordy);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        prod_valid = v;
        prod_first = f;
        prod       = 8'(p);
        out_ready  = ordy;
        #1;
        exp_rdy = !(pos == 3 && m_valid && !ordy);
        chk("prod_ready", int'(prod_ready), int'(exp_rdy));
        acc     = v && exp_rdy;
        m_err   = 1'b0;
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            if (f) begin
                m_err    = (pos != 0);
                terms[0] = p;
                pos      = 1;
            end else if (pos == 0) begin
                m_err = 1'b1;
            end else begin
                terms[pos] = p;
                if (pos == 3) begin
                    m_re    = terms[0] - terms[1];
                    m_im    = terms[2] + terms[3];
                    m_valid = 1'b1;
                    pos     = 0;
                end else begin
                    pos++;
                end
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("frame_err", int'(frame_err), int'(m_err));
        if (m_valid) begin
            chk("re", int'(re), m_re);
            chk("im", int'(im), m_im);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        prod       = '0;
        prod_valid = 1'b0;
        prod_first = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_re", int'(re), 0);
        chk("rst_im", int'(im), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_prod_ready", int'(prod_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Nominal frame: (3+j2)*(4+j5)
        step(1, 1, 12, 1);
        step(1, 0, 10, 1);
        step(1, 0, 15, 1);
        step(1, 0, 8, 1);
        chk("nom_valid", int'(out_valid), 1);
        chk("nom_re", int'(re), 2);
        chk("nom_im", int'(im), 23);
        idle();
        chk("nom_valid_drop", int'(out_valid), 0);

        // Extreme operands, no wrap
        step(1, 1, -128, 1);
        step(1, 0, 127, 1);
        step(1, 0, 127, 1);
        step(1, 0, 127, 1);
        chk("ext_re", int'(re), -255);
        chk("ext_im", int'(im), 254);
        idle();

        // Backpressure across two frames
        step(1, 1, 1, 0);
        step(1, 0, 2, 0);
        step(1, 0, 3, 0);
        step(1, 0, 4, 0);           // first result: re=-1, im=7
        step(1, 1, 5, 0);
        step(1, 0, 1, 0);
        step(1, 0, 6, 0);
        step(1, 0, 7, 0);           // bc must stall
        chk("bp_stall", int'(last_acc), 0);
        chk("bp_hold_re", int'(re), -1);
        chk("bp_hold_im", int'(im), 7);
        step(1, 0, 7, 1);           // consume old, load new on the same edge
        chk("bp_accept", int'(last_acc), 1);
        chk("bp_new_re", int'(re), 4);
        chk("bp_new_im", int'(im), 13);
        chk("bp_new_valid", int'(out_valid), 1);
        idle();

        // Restart mid-frame
        step(1, 1, 5, 1);
        step(1, 0, 6, 1);
        step(1, 1, 7, 1);
        chk("restart_err", int'(frame_err), 1);
        step(1, 0, 8, 1);
        chk("restart_err_pulse", int'(frame_err), 0);
        step(1, 0, 9, 1);
        step(1, 0, 10, 1);
        chk("restart_re", int'(re), -1);
        chk("restart_im", int'(im), 19);
        idle();

        // Orphan word in EXP_AC
        step(1, 0, 9, 1);
        chk("orphan_err", int'(frame_err), 1);
        chk("orphan_valid", int'(out_valid), 0);
        idle();

        // Asynchronous reset mid-frame
        step(1, 1, 20, 1);
        step(1, 0, 30, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_re", int'(re), 0);
        chk("arst_im", int'(im), 0);
        chk("arst_valid", int'(out_valid), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 1, 1);
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        chk("post_rst_re", int'(re), 0);
        chk("post_rst_im", int'(im), 2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit f;
            bit r;
            v = ($urandom % 4) != 0;
            if (pos == 0) f = ($urandom % 8) != 0;
            else          f = ($urandom % 12) == 0;
            r = ($urandom % 5) < 3;
            step(v, f, int'($signed(8'($urandom))), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
